// File: rtl/serial_compare_pkg.sv
// rtl/serial_compare_pkg.sv - shared state encoding and default width for the serial comparator
package serial_compare_pkg;

    localparam int DEFAULT_N = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_compare_bit_eq.sv
// rtl/serial_compare_bit_eq.sv - single-bit equality cell (xnor)
module bit_eq (
    input  logic a,
    input  logic b,
    output logic eq
);

    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_compare.sv
// rtl/serial_compare.sv - MSB-first serial unsigned comparator with start/abort handshake
module serial_compare
    import serial_compare_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic bit_valid,
    input  logic x_bit,
    input  logic y_bit,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CW = $clog2(N + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_gt_q, dec_gt_d;
    logic          dec_lt_q, dec_lt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;
    logic          pair_eq;

    bit_eq u_bit_eq (
        .a  (x_bit),
        .b  (y_bit),
        .eq (pair_eq)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dec_gt_d = dec_gt_q;
        dec_lt_d = dec_lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous abort cancels the request before it is taken.
                if (start && !abort) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = '0;
                    dec_gt_d = 1'b0;
                    dec_lt_d = 1'b0;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    dec_gt_d = 1'b0;
                    dec_lt_d = 1'b0;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                end else if (bit_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!dec_gt_q && !dec_lt_q && !pair_eq) begin
                        dec_gt_d = x_bit;
                        dec_lt_d = y_bit;
                    end
                    // Results are published on the final pair, including its own decision.
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_DONE;
                        eq_d    = !(dec_gt_d || dec_lt_d);
                        gt_d    = dec_gt_d;
                        lt_d    = dec_lt_d;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dec_gt_q <= 1'b0;
            dec_lt_q <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dec_gt_q <= dec_gt_d;
            dec_lt_q <= dec_lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_compare.sv
// tb/tb_serial_compare.sv - directed and randomized bench for serial_compare
module tb_serial_compare;

    localparam int N = 5;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start     = 1'b0;
    logic abort     = 1'b0;
    logic bit_valid = 1'b0;
    logic x_bit     = 1'b0;
    logic y_bit     = 1'b0;
    logic busy, done, eq, gt, lt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_compare #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_valid (bit_valid),
        .x_bit     (x_bit),
        .y_bit     (y_bit),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

    // Expected {eq, gt, lt} from plain integer comparison of the operands.
    function automatic logic [2:0] model(input int x, input int y);
        return {x == y, x > y, x < y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_cmp(input string tag, input int x, input int y,
                           input int stall_after, input int stall_len);
        logic [2:0] exp;
        logic       early_done;
        exp        = model(x, y);
        early_done = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_in_shift"}, busy, 1);
        check({tag, " flags_cleared"}, {eq, gt, lt}, 3'b000);
        for (int i = N - 1; i >= 0; i--) begin
            if (N - 1 - i == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valid = 1'b0;
                    x_bit     = 1'($urandom);
                    y_bit     = 1'($urandom);
                    @(negedge clk);
                    early_done |= done;
                end
            end
            bit_valid = 1'b1;
            x_bit     = 1'(x >> i);
            y_bit     = 1'(y >> i);
            @(negedge clk);
            if (i != 0) early_done |= done;
        end
        bit_valid = 1'b0;
        check({tag, " no_early_done"}, early_done, 0);
        check({tag, " done"}, done, 1);
        check({tag, " flags"}, {eq, gt, lt}, exp);
        check({tag, " busy_in_done"}, busy, 0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " flags_held"}, {eq, gt, lt}, exp);
    endtask

    initial begin
        logic acc;
        int   x, y;

        #12;
        check("reset_outputs", {busy, done, eq, gt, lt}, 5'b00000);
        // Start presented together with reset release must be taken on the next edge.
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_start_after_reset", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cleanup", {busy, done}, 2'b00);

        run_cmp("eq_10111", 'b10111, 'b10111, 0, 0);
        run_cmp("lt_10111_11111", 'b10111, 'b11111, 0, 0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_flags", {eq, gt, lt}, 3'b001);

        run_cmp("gt_stall3", 'b11111, 'b00000, 2, 3);

        // Abort wins over a simultaneous valid bit pair.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b1;
        x_bit     = 1'b1;
        y_bit     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        x_bit = 1'b1;
        y_bit = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flags", {eq, gt, lt}, 3'b000);
        acc = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            acc |= done | busy;
        end
        bit_valid = 1'b0;
        check("abort_no_done_later", acc, 0);
        run_cmp("after_abort", 'b01100, 'b01010, 0, 0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b1;
        x_bit     = 1'b0;
        y_bit     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, eq, gt, lt}, 5'b00000);
        #3;
        rst_n = 1'b1;
        acc   = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            acc |= done | busy;
        end
        bit_valid = 1'b0;
        check("reset_no_done_after", acc, 0);

        // Start held high: one done, no restart until back in IDLE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("held_start_busy", busy, 1);
        acc = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            x_bit     = 1'b0;
            y_bit     = 1'b0;
            @(negedge clk);
            if (i != 0) acc |= done | !busy;
        end
        bit_valid = 1'b0;
        check("held_start_no_restart", acc, 0);
        check("held_start_done", done, 1);
        check("held_start_flags", {eq, gt, lt}, 3'b100);
        @(negedge clk);
        check("held_start_idle", {busy, done}, 2'b00);
        @(negedge clk);
        check("held_start_rearm", busy, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        for (int k = 0; k < 24; k++) begin
            x = int'($urandom_range(0, (1 << N) - 1));
            y = ($urandom_range(0, 3) == 0) ? x : int'($urandom_range(0, (1 << N) - 1));
            run_cmp($sformatf("rand%0d", k), x, y,
                    int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
